// File: rtl/sched_pkg.sv
// -----------------------------------------------------------------------------
// sched_pkg
// Shared definitions for the sample scheduler: FSM state encoding, the default
// frame delay, counter widths and a helper that normalises the requested delay.
// -----------------------------------------------------------------------------
package sched_pkg;

    // Scheduler states: IDLE waits for a frame tick, DELAY counts down to the
    // master tick, WAIT sequences the filter stages one after another.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_WAIT  = 2'd2
    } sched_state_e;

    // Nominal ADC-tick to master-tick delay used by typical configurations.
    localparam int unsigned DEFAULT_DELAY = 100;

    // Width of delay_i.
    localparam int unsigned DELAY_W = 10;

    // Width of the shared delay/timeout down-counter; sized so that any
    // TIMEOUT_CYCLES up to 65535 and any 10-bit delay fit.
    localparam int unsigned TIMER_W = 16;

    // Width of a stage index (up to 8 stages).
    localparam int unsigned STAGE_W = 3;

    // A requested delay of zero behaves exactly like a delay of one.
    function automatic logic [DELAY_W-1:0] eff_delay(input logic [DELAY_W-1:0] d);
        return (d == '0) ? DELAY_W'(1) : d;
    endfunction

endpackage

// File: rtl/tick_delay_counter.sv
// -----------------------------------------------------------------------------
// tick_delay_counter
// Reloadable saturating down-counter. The scheduler uses one instance for both
// the tick-to-master delay and the per-stage timeout, since the two are never
// active at the same time.
//
// Ports:
//   clk_i       system clock, rising edge
//   reset_ni    asynchronous active-low reset (count returns to 0)
//   load_i      load load_val_i this cycle (takes priority over dec_i)
//   load_val_i  reload value
//   dec_i       decrement by one when not already zero
//   zero_o      count is zero
// -----------------------------------------------------------------------------
module tick_delay_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] r_count;

    // NOTE: clocked state is always written with non-blocking assignments so
    // every flop samples the pre-edge values of the others, independent of
    // the order in which simulator processes run.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_count <= '0;
        end else if (load_i) begin
            r_count <= load_val_i;
        end else if (dec_i && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign zero_o = (r_count == '0);

endmodule

// File: rtl/sample_scheduler.sv
// -----------------------------------------------------------------------------
// sample_scheduler
// Turns each accepted ADC frame tick into a delayed master tick, then starts a
// chain of filter stages one at a time, waiting for each stage's done pulse
// (with a timeout) before starting the next. Reports frame completion, tick
// overruns and stage timeouts, and counts master ticks.
//
// Parameters:
//   NUM_STAGES      number of sequenced filter stages (1..8)
//   TIMEOUT_CYCLES  cycles allowed from a stage start to its done (1..65535)
//
// Ports:
//   clk_i           system clock, rising edge
//   reset_ni        asynchronous active-low reset
//   adc_tick_i      one-cycle pulse marking a new ADC frame
//   enable_i        high permits new frames to be accepted
//   delay_i         cycles from accepted tick to master_tick_o (0 acts as 1)
//   clear_i         clears overrun_o and timeout_o
//   stage_done_i    per-stage one-cycle done pulses
//   stage_start_o   one-hot one-cycle stage start pulses
//   master_tick_o   one-cycle delayed frame tick (coincides with start[0])
//   frame_done_o    one-cycle pulse after the last stage completes
//   busy_o          high whenever the scheduler is not idle
//   overrun_o       sticky: an enabled tick arrived while busy
//   timeout_o       sticky: a stage missed its timeout
//   error_stage_o   index of the stage that timed out
//   sample_count_o  number of master ticks issued, wrapping
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module sample_scheduler
    import sched_pkg::*;
#(
    parameter int unsigned NUM_STAGES     = 3,
    parameter int unsigned TIMEOUT_CYCLES = 4095
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  adc_tick_i,
    input  logic                  enable_i,
    input  logic [DELAY_W-1:0]    delay_i,
    input  logic                  clear_i,
    input  logic [NUM_STAGES-1:0] stage_done_i,
    output logic [NUM_STAGES-1:0] stage_start_o,
    output logic                  master_tick_o,
    output logic                  frame_done_o,
    output logic                  busy_o,
    output logic                  overrun_o,
    output logic                  timeout_o,
    output logic [STAGE_W-1:0]    error_stage_o,
    output logic [31:0]           sample_count_o
);

    // The counter reaches zero on the last cycle of a wait, so it is loaded
    // with (length - 1) for a timeout. For the delay, the first cycle is spent
    // on the accepting edge and the master tick is registered one edge before
    // it becomes visible, hence (D - 2); D == 1 bypasses DELAY altogether.
    localparam logic [TIMER_W-1:0]    TIMEOUT_PRELOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_STAGES-1:0] FIRST_STAGE_OH  = NUM_STAGES'(1);
    localparam logic [STAGE_W-1:0]    LAST_STAGE      = STAGE_W'(NUM_STAGES - 1);

    // ------------------------------------------------------------------
    // Registered state and outputs
    // ------------------------------------------------------------------
    sched_state_e          r_state;
    logic [STAGE_W-1:0]    r_stage;
    logic [NUM_STAGES-1:0] r_stage_start;
    logic                  r_master_tick;
    logic                  r_frame_done;
    logic                  r_busy;
    logic                  r_overrun;
    logic                  r_timeout;
    logic [STAGE_W-1:0]    r_error_stage;
    logic [31:0]           r_sample_count;

    // ------------------------------------------------------------------
    // Decoded events for this cycle
    // ------------------------------------------------------------------
    logic [DELAY_W-1:0]    w_delay_eff;
    logic                  w_cur_done;
    logic                  w_is_last;
    logic                  w_final_done;
    logic                  w_accept;
    logic                  w_overrun_evt;
    logic                  w_immediate;
    logic                  w_delay_expire;
    logic                  w_fire_master;
    logic                  w_stage_adv;
    logic [NUM_STAGES-1:0] w_next_oh;
    logic                  w_cnt_load;
    logic [TIMER_W-1:0]    w_cnt_val;
    logic                  w_cnt_dec;
    logic                  w_cnt_zero;

    // NOTE: every signal written here gets a default at the top of the block;
    // any path that left one unassigned would infer a latch.
    always_comb begin
        w_delay_eff = eff_delay(delay_i);

        // Only the done pulse of the stage currently being waited on counts.
        w_cur_done = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (r_stage == STAGE_W'(i)) begin
                w_cur_done = stage_done_i[i];
            end
        end

        w_next_oh = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            w_next_oh[i] = (STAGE_W'(i) == (r_stage + STAGE_W'(1)));
        end

        w_is_last    = (r_stage == LAST_STAGE);
        w_final_done = (r_state == ST_WAIT) && w_cur_done && w_is_last;

        // A tick coinciding with the last done starts the next frame cleanly.
        w_accept      = adc_tick_i && enable_i && ((r_state == ST_IDLE) || w_final_done);
        w_overrun_evt = adc_tick_i && enable_i && (r_state != ST_IDLE) && !w_final_done;

        w_immediate    = w_accept && (w_delay_eff == DELAY_W'(1));
        w_delay_expire = (r_state == ST_DELAY) && w_cnt_zero;
        w_fire_master  = w_immediate || w_delay_expire;
        w_stage_adv    = (r_state == ST_WAIT) && w_cur_done && !w_is_last;

        // Any stage start (including start[0] with the master tick) arms the
        // timeout; an accepted tick with D > 1 arms the delay.
        w_cnt_load = w_accept || w_delay_expire || w_stage_adv;
        if (w_fire_master || w_stage_adv) begin
            w_cnt_val = TIMEOUT_PRELOAD;
        end else begin
            w_cnt_val = TIMER_W'(w_delay_eff) - TIMER_W'(2);
        end
        w_cnt_dec = (r_state != ST_IDLE);
    end

    tick_delay_counter #(
        .WIDTH      (TIMER_W)
    ) u_counter (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .load_i     (w_cnt_load),
        .load_val_i (w_cnt_val),
        .dec_i      (w_cnt_dec),
        .zero_o     (w_cnt_zero)
    );

    // ------------------------------------------------------------------
    // Scheduler FSM. Later assignments in this block deliberately override
    // earlier ones: a new frame overrides the return to IDLE after the last
    // stage, a master tick overrides DELAY entry, and a flag-setting event
    // overrides clear_i.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state        <= ST_IDLE;
            r_stage        <= '0;
            r_stage_start  <= '0;
            r_master_tick  <= 1'b0;
            r_frame_done   <= 1'b0;
            r_busy         <= 1'b0;
            r_overrun      <= 1'b0;
            r_timeout      <= 1'b0;
            r_error_stage  <= '0;
            r_sample_count <= '0;
        end else begin
            r_stage_start <= '0;
            r_master_tick <= 1'b0;
            r_frame_done  <= 1'b0;

            if (clear_i) begin
                r_overrun <= 1'b0;
                r_timeout <= 1'b0;
            end
            if (w_overrun_evt) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    // Frame acceptance is handled below.
                end
                ST_DELAY: begin
                    // Delay expiry is handled with the master tick below.
                end
                ST_WAIT: begin
                    if (w_cur_done) begin
                        if (w_is_last) begin
                            r_frame_done <= 1'b1;
                            r_state      <= ST_IDLE;
                            r_busy       <= 1'b0;
                        end else begin
                            r_stage       <= r_stage + STAGE_W'(1);
                            r_stage_start <= w_next_oh;
                        end
                    end else if (w_cnt_zero) begin
                        r_timeout     <= 1'b1;
                        r_error_stage <= r_stage;
                        r_state       <= ST_IDLE;
                        r_busy        <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            if (w_accept) begin
                r_state <= ST_DELAY;
                r_busy  <= 1'b1;
            end

            if (w_fire_master) begin
                r_master_tick  <= 1'b1;
                r_stage_start  <= FIRST_STAGE_OH;
                r_stage        <= '0;
                r_state        <= ST_WAIT;
                r_busy         <= 1'b1;
                r_sample_count <= r_sample_count + 32'd1;
            end
        end
    end

    assign stage_start_o  = r_stage_start;
    assign master_tick_o  = r_master_tick;
    assign frame_done_o   = r_frame_done;
    assign busy_o         = r_busy;
    assign overrun_o      = r_overrun;
    assign timeout_o      = r_timeout;
    assign error_stage_o  = r_error_stage;
    assign sample_count_o = r_sample_count;

endmodule

// File: tb/tb_sample_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sample_scheduler
// Directed bench for sample_scheduler (NUM_STAGES=3, TIMEOUT_CYCLES=4095).
// Cycle c is the clock period that starts at rising edge c; outputs are read
// and inputs driven 1 ns after that edge. A tick driven in cycle 0 with delay
// D must show master_tick_o in cycle D.
// -----------------------------------------------------------------------------
module tb_sample_scheduler;
    import sched_pkg::*;

    localparam int NS = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          adc_tick;
    logic          enable;
    logic [9:0]    delay;
    logic          clear;
    logic [NS-1:0] done;
    logic [NS-1:0] stage_start;
    logic          master_tick;
    logic          frame_done;
    logic          busy;
    logic          overrun;
    logic          timeout;
    logic [2:0]    error_stage;
    logic [31:0]   sample_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_count = 32'd0;

    always #5 clk = ~clk;

    sample_scheduler #(
        .NUM_STAGES     (NS),
        .TIMEOUT_CYCLES (4095)
    ) dut (
        .clk_i          (clk),
        .reset_ni       (reset_n),
        .adc_tick_i     (adc_tick),
        .enable_i       (enable),
        .delay_i        (delay),
        .clear_i        (clear),
        .stage_done_i   (done),
        .stage_start_o  (stage_start),
        .master_tick_o  (master_tick),
        .frame_done_o   (frame_done),
        .busy_o         (busy),
        .overrun_o      (overrun),
        .timeout_o      (timeout),
        .error_stage_o  (error_stage),
        .sample_count_o (sample_count)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic t, input logic [9:0] d, input logic [NS-1:0] dn, input logic clr);
        adc_tick = t;
        delay    = d;
        done     = dn;
        clear    = clr;
    endtask

    task automatic test_reset();
        logic [45:0] got;
        reset_n = 1'b0;
        enable  = 1'b1;
        drive(1'b0, 10'd0, '0, 1'b0);
        repeat (2) next_cycle();
        got = {stage_start, master_tick, frame_done, busy, overrun, timeout, error_stage, sample_count};
        n_checks++;
        if (got !== '0) begin
            n_fail++;
            $display("FAIL reset_held: got %h required 0", got);
        end
        reset_n = 1'b1;
        next_cycle();
        got = {stage_start, master_tick, frame_done, busy, overrun, timeout, error_stage, sample_count};
        n_checks++;
        if (got !== '0) begin
            n_fail++;
            $display("FAIL reset_released: got %h required 0", got);
        end
    endtask

    task automatic test_basic_frame();
        logic [NS-1:0] dn, es;
        logic [5:0]    got, exp;
        next_cycle();
        drive(1'b1, 10'(DEFAULT_DELAY), '0, 1'b0);
        for (int c = 1; c <= 135; c++) begin
            next_cycle();
            es  = (c == 100) ? 3'b001 : (c == 111) ? 3'b010 : (c == 121) ? 3'b100 : 3'b000;
            got = {master_tick, stage_start, frame_done, busy};
            exp = {c == 100, es, c == 131, (c >= 1 && c <= 130)};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL basic_frame c=%0d: got %b required %b", c, got, exp);
            end
            dn = (c == 110) ? 3'b001 : (c == 120) ? 3'b010 : (c == 130) ? 3'b100 : 3'b000;
            drive(1'b0, 10'(DEFAULT_DELAY), dn, 1'b0);
        end
        exp_count = exp_count + 32'd1;
        n_checks++;
        if (sample_count !== exp_count) begin
            n_fail++;
            $display("FAIL basic_count: got %0d required %0d", sample_count, exp_count);
        end
    endtask

    task automatic test_overrun();
        logic [NS-1:0] dn, es;
        logic [6:0]    got, exp;
        next_cycle();
        drive(1'b1, 10'd20, '0, 1'b0);
        for (int c = 1; c <= 70; c++) begin
            next_cycle();
            es  = (c == 20) ? 3'b001 : (c == 61) ? 3'b010 : (c == 63) ? 3'b100 : 3'b000;
            got = {master_tick, stage_start, frame_done, busy, overrun};
            exp = {c == 20, es, c == 65, (c >= 1 && c <= 64), c >= 51};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL overrun c=%0d: got %b required %b", c, got, exp);
            end
            dn = (c == 60) ? 3'b001 : (c == 62) ? 3'b010 : (c == 64) ? 3'b100 : 3'b000;
            drive(c == 50, 10'd20, dn, 1'b0);
        end
        exp_count = exp_count + 32'd1;
        n_checks++;
        if (sample_count !== exp_count) begin
            n_fail++;
            $display("FAIL overrun_count: got %0d required %0d", sample_count, exp_count);
        end
        drive(1'b0, 10'd20, '0, 1'b1);
        next_cycle();
        drive(1'b0, 10'd20, '0, 1'b0);
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear: got %b required 0", overrun);
        end
    endtask

    task automatic test_timeout();
        logic [NS-1:0] es;
        logic [6:0]    got, exp;
        next_cycle();
        drive(1'b1, 10'd5, '0, 1'b0);
        for (int c = 1; c <= 4105; c++) begin
            next_cycle();
            es  = (c == 5) ? 3'b001 : (c == 7) ? 3'b010 : 3'b000;
            got = {master_tick, stage_start, frame_done, busy, timeout};
            exp = {c == 5, es, 1'b0, (c >= 1 && c <= 4101), c >= 4102};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL timeout c=%0d: got %b required %b", c, got, exp);
            end
            drive(1'b0, 10'd5, (c == 6) ? 3'b001 : 3'b000, 1'b0);
        end
        exp_count = exp_count + 32'd1;
        n_checks++;
        if (error_stage !== 3'd1) begin
            n_fail++;
            $display("FAIL timeout_stage: got %0d required 1", error_stage);
        end
        drive(1'b0, 10'd5, '0, 1'b1);
        next_cycle();
        drive(1'b0, 10'd5, '0, 1'b0);
        n_checks++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear: got %b required 0", timeout);
        end
    endtask

    task automatic test_back_to_back();
        logic [NS-1:0] dn, es;
        logic [6:0]    got, exp;
        next_cycle();
        drive(1'b1, 10'd10, '0, 1'b0);
        for (int c = 1; c <= 30; c++) begin
            next_cycle();
            case (c)
                10, 22:  es = 3'b001;
                12, 24:  es = 3'b010;
                14, 26:  es = 3'b100;
                default: es = 3'b000;
            endcase
            got = {master_tick, stage_start, frame_done, busy, overrun};
            exp = {(c == 10 || c == 22), es, (c == 16 || c == 28), (c >= 1 && c <= 27), 1'b0};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL back_to_back c=%0d: got %b required %b", c, got, exp);
            end
            case (c)
                11, 23:  dn = 3'b001;
                13, 25:  dn = 3'b010;
                15, 27:  dn = 3'b100;
                default: dn = 3'b000;
            endcase
            drive(c == 15, 10'd7, dn, 1'b0);
        end
        exp_count = exp_count + 32'd2;
        n_checks++;
        if (sample_count !== exp_count) begin
            n_fail++;
            $display("FAIL back_to_back_count: got %0d required %0d", sample_count, exp_count);
        end
    endtask

    task automatic test_enable_and_ignore();
        logic [NS-1:0] dn, es;
        logic [6:0]    got, exp;
        next_cycle();
        enable = 1'b0;
        drive(1'b1, 10'd2, '0, 1'b0);
        for (int c = 1; c <= 17; c++) begin
            next_cycle();
            es  = (c == 6) ? 3'b001 : (c == 10) ? 3'b010 : (c == 13) ? 3'b100 : 3'b000;
            got = {master_tick, stage_start, frame_done, busy, overrun};
            exp = {c == 6, es, c == 15, (c >= 5 && c <= 14), 1'b0};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL enable_ignore c=%0d: got %b required %b", c, got, exp);
            end
            case (c)
                7:       dn = 3'b010;
                9:       dn = 3'b001;
                11:      dn = 3'b100;
                12:      dn = 3'b010;
                14:      dn = 3'b100;
                default: dn = 3'b000;
            endcase
            enable = (c >= 4 && c < 8);
            drive(c == 4 || c == 8, 10'd2, dn, 1'b0);
        end
        enable    = 1'b1;
        exp_count = exp_count + 32'd1;
        n_checks++;
        if (sample_count !== exp_count) begin
            n_fail++;
            $display("FAIL enable_count: got %0d required %0d", sample_count, exp_count);
        end
    endtask

    task automatic test_clear_coincident();
        logic [NS-1:0] dn, es;
        logic [6:0]    got, exp;
        next_cycle();
        drive(1'b1, 10'd5, '0, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            next_cycle();
            es  = (c == 5) ? 3'b001 : (c == 7) ? 3'b010 : (c == 9) ? 3'b100 : 3'b000;
            got = {master_tick, stage_start, frame_done, busy, overrun};
            exp = {c == 5, es, c == 11, (c >= 1 && c <= 10), c >= 3};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL clear_coincident c=%0d: got %b required %b", c, got, exp);
            end
            dn = (c == 6) ? 3'b001 : (c == 8) ? 3'b010 : (c == 10) ? 3'b100 : 3'b000;
            drive(c == 2 || c == 3, 10'd5, dn, c == 3);
        end
        exp_count = exp_count + 32'd1;
        next_cycle();
        drive(1'b0, 10'd5, '0, 1'b1);
        next_cycle();
        drive(1'b0, 10'd5, '0, 1'b0);
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_alone: got %b required 0", overrun);
        end
        n_checks++;
        if (sample_count !== exp_count) begin
            n_fail++;
            $display("FAIL clear_count: got %0d required %0d", sample_count, exp_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [45:0] all;
        logic [6:0]  got;
        next_cycle();
        drive(1'b1, 10'd3, '0, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            drive(c == 4, 10'd3, '0, 1'b0);
        end
        n_checks++;
        if (busy !== 1'b1 || sample_count !== exp_count + 32'd1 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_frame_setup: got busy=%b overrun=%b count=%0d required 1 1 %0d",
                     busy, overrun, sample_count, exp_count + 32'd1);
        end
        #2;
        reset_n = 1'b0;
        #1;
        all = {stage_start, master_tick, frame_done, busy, overrun, timeout, error_stage, sample_count};
        n_checks++;
        if (all !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_frame: got %h required 0", all);
        end
        exp_count = 32'd0;
        drive(1'b0, 10'd3, 3'b001, 1'b0);
        next_cycle();
        drive(1'b0, 10'd3, '0, 1'b0);
        reset_n = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            next_cycle();
            got = {master_tick, stage_start, frame_done, busy, overrun};
            n_checks++;
            if (got !== '0) begin
                n_fail++;
                $display("FAIL post_reset_quiet c=%0d: got %b required 0", c, got);
            end
            drive(1'b0, 10'd3, (c % 4 == 1) ? 3'b001 : 3'b000, 1'b0);
        end
        n_checks++;
        if (sample_count !== exp_count) begin
            n_fail++;
            $display("FAIL post_reset_count: got %0d required %0d", sample_count, exp_count);
        end
    endtask

    task automatic test_wrap_and_zero_delay();
        logic [NS-1:0] dn, es;
        logic [5:0]    got, exp;
        next_cycle();
        force dut.r_sample_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_sample_count;
        drive(1'b1, 10'd0, '0, 1'b0);
        exp_count = 32'd0;
        for (int c = 1; c <= 7; c++) begin
            next_cycle();
            es  = (c == 1) ? 3'b001 : (c == 3) ? 3'b010 : (c == 5) ? 3'b100 : 3'b000;
            got = {master_tick, stage_start, frame_done, busy};
            exp = {c == 1, es, c == 6, (c >= 1 && c <= 5)};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL zero_delay c=%0d: got %b required %b", c, got, exp);
            end
            if (c == 1) begin
                n_checks++;
                if (sample_count !== exp_count) begin
                    n_fail++;
                    $display("FAIL count_wrap: got %h required %h", sample_count, exp_count);
                end
            end
            dn = (c == 2) ? 3'b001 : (c == 4) ? 3'b010 : (c == 5) ? 3'b100 : 3'b000;
            drive(1'b0, 10'd0, dn, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_overrun();
        test_timeout();
        test_back_to_back();
        test_enable_and_ignore();
        test_clear_coincident();
        test_reset_mid_frame();
        test_wrap_and_zero_delay();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sample_scheduler.md
SAMPLE_SCHEDULER -- requirements
Module: sample_scheduler

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 3, number of sequenced filter stages (1..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4095, maximum cycles allowed from a stage start to its done.
REQ-003 SHALL have port clk_i, input, 1, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_ni, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port adc_tick_i, input, 1, one-cycle pulse marking a new ADC frame.
REQ-006 SHALL have port enable_i, input, 1, high permits new frames.
REQ-007 SHALL have port delay_i, input, 10, unsigned cycles from adc_tick_i to master_tick_o; sampled on tick acceptance.
REQ-008 SHALL have port clear_i, input, 1, clears sticky error flags.
REQ-009 SHALL have port stage_done_i, input, NUM_STAGES, per-stage one-cycle done pulses.
REQ-010 SHALL have port stage_start_o, output, NUM_STAGES, one-hot one-cycle start pulses.
REQ-011 SHALL have port master_tick_o, output, 1, delayed one-cycle frame tick.
REQ-012 SHALL have port frame_done_o, output, 1, one-cycle pulse after the last stage completes.
REQ-013 SHALL have port busy_o, output, 1, high in any state other than IDLE.
REQ-014 SHALL have port overrun_o, output, 1, sticky: a tick arrived while busy.
REQ-015 SHALL have port timeout_o, output, 1, sticky: a stage exceeded TIMEOUT_CYCLES.
REQ-016 SHALL have port error_stage_o, output, 3, index of the stage that timed out.
REQ-017 SHALL have port sample_count_o, output, 32, unsigned count of master ticks.

Function
REQ-018 SHALL implement the states IDLE, DELAY and WAIT.
REQ-019 SHALL, in IDLE, accept adc_tick_i only when enable_i=1, latching delay_i D and entering DELAY.
REQ-020 SHALL treat D=0 as D=1.
REQ-021 SHALL assert master_tick_o and stage_start_o[0] together exactly D cycles after the accepting tick cycle, then enter WAIT for stage 0.
REQ-022 SHALL, in WAIT for stage k, act on stage_done_i[k] only; done pulses from other stages are ignored.
REQ-023 SHALL, on stage_done_i[k] with k<NUM_STAGES-1, pulse stage_start_o[k+1] in the next cycle and restart the timeout counter.
REQ-024 SHALL, on stage_done_i[NUM_STAGES-1], pulse frame_done_o in the next cycle and return to IDLE in that same cycle.
REQ-025 SHALL, if stage k has no done within TIMEOUT_CYCLES cycles of its start, set timeout_o, set error_stage_o=k, return to IDLE, and issue no frame_done_o.
REQ-026 SHALL, when adc_tick_i=1 in DELAY or WAIT, set overrun_o and otherwise ignore the tick; the frame in progress continues.
REQ-027 SHALL accept a tick arriving in the same cycle as the final stage_done_i as a new frame, without setting overrun_o.
REQ-028 SHALL, when enable_i=0, finish any frame in progress and ignore new ticks without setting overrun_o.
REQ-029 SHALL increment sample_count_o on each master_tick_o, wrapping modulo 2^32.
REQ-030 SHALL clear overrun_o and timeout_o on clear_i; a set event coinciding with clear_i wins.
REQ-031 SHALL keep all outputs registered, with no combinational path from inputs to outputs.

Reset
REQ-032 SHALL, while reset_ni=0, force state IDLE, all pulse outputs 0, busy_o 0, both sticky flags 0, error_stage_o 0 and sample_count_o 0.
REQ-033 SHALL abort any frame in progress on a mid-frame reset; no pulse is emitted after reset_ni deasserts until a new tick is accepted.

Structure
REQ-034 SHALL take the state enum, DEFAULT_DELAY=100 and the timeout counter width from the shared package sched_pkg.
REQ-035 SHALL implement the reloadable down-counter, shared by the delay and timeout functions, as the single sub-module tick_delay_counter.

Verification
REQ-036 SHALL cover: delay_i=100, tick at cycle 0 -> master_tick_o and stage_start_o=001 at cycle 100; done[0] at 110 -> start=010 at 111; done[1] at 120 -> start=100 at 121; done[2] at 130 -> frame_done_o at 131; sample_count_o=1.
REQ-037 SHALL cover: second tick 50 cycles into a frame -> overrun_o=1, sample_count_o unchanged, frame completes normally.
REQ-038 SHALL cover: stage 1 never done, TIMEOUT_CYCLES=4095 -> timeout_o=1 4095 cycles after start[1], error_stage_o=1, busy_o=0, no frame_done_o.
REQ-039 SHALL cover: tick coincident with done[2] -> no overrun, next master_tick_o D cycles later.
REQ-040 SHALL cover: reset_ni low during WAIT -> all outputs 0 immediately; clear_i coincident with overrun event -> overrun_o stays 1.
REQ-041 SHALL cover: sample_count_o preset near 0xFFFFFFFF -> wraps to 0 on the next master tick; delay_i=0 -> master tick 1 cycle after tick.
